// File: rtl/sync_word_pkg.sv
// Shared types and constants for the serial sync-word detector.
package sync_word_pkg;

    localparam int WORD_W  = 32;
    localparam int COUNT_W = 16;
    localparam int FILL_W  = 6;
    localparam int PHASE_W = 5;
    localparam int CNT_W   = 4;

    localparam logic [WORD_W-1:0] DEFAULT_SYNC_WORD = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } sync_state_t;

endpackage

// File: rtl/sync_word_shift.sv
// Serial shift register, fill tracking and sync-word comparators.
// Inverted-word matching is enabled by defining SYNC_WORD_DETECTOR_INV_EN.
module sync_word_shift
    import sync_word_pkg::*;
#(
    parameter logic [WORD_W-1:0] SYNC_WORD = DEFAULT_SYNC_WORD
) (
    input  logic clk,
    input  logic reset,
    input  logic in_val,
    input  logic in_bit,
    output logic hit,
    output logic hit_pol
);

    logic [WORD_W-1:0] sr_q;
    logic [WORD_W-1:0] sr_next;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_next;
    logic              is_true;
    logic              is_inv;
    logic              full_next;

    always_comb begin
        sr_next   = {sr_q[WORD_W-2:0], in_bit};
        fill_next = (fill_q == FILL_W'(WORD_W)) ? fill_q : fill_q + FILL_W'(1);
        full_next = (fill_next == FILL_W'(WORD_W));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q   <= '0;
            fill_q <= '0;
        end else if (in_val) begin
            sr_q   <= sr_next;
            fill_q <= fill_next;
        end
    end

    // Compare the post-shift word so the hit lines up with the accepting edge.
    assign is_true = (sr_next == SYNC_WORD);

`ifdef SYNC_WORD_DETECTOR_INV_EN
    assign is_inv = (sr_next == ~SYNC_WORD);
`else
    assign is_inv = 1'b0;
`endif

    assign hit     = in_val && full_next && (is_true || is_inv);
    assign hit_pol = is_inv && !is_true;

endmodule

// File: rtl/sync_word_detector.sv
// Serial sync-word detector with SEARCH/VERIFY/LOCKED framing FSM.
// Define SYNC_WORD_DETECTOR_INV_EN to also accept the bit-inverted sync word.
module sync_word_detector
    import sync_word_pkg::*;
#(
    parameter logic [WORD_W-1:0] SYNC_WORD  = DEFAULT_SYNC_WORD,
    parameter int unsigned       LOCK_COUNT = 3,
    parameter int unsigned       LOSS_COUNT = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_val,
    input  logic               in_bit,
    output logic               match,
    output logic               locked,
    output logic [1:0]         state,
    output logic [COUNT_W-1:0] match_count,
    output logic               polarity
);

    localparam logic [CNT_W-1:0] LOCK_N = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] LOSS_N = CNT_W'(LOSS_COUNT);

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == {COUNT_W{1'b1}}) ? v : v + COUNT_W'(1);
    endfunction

    logic               hit;
    logic               hit_pol;
    sync_state_t        state_q, state_d;
    logic [CNT_W-1:0]   good_q, good_d;
    logic [CNT_W-1:0]   miss_q, miss_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               pol_q, pol_d;
    logic               at_boundary;
    logic               same_hit;

    sync_word_shift #(
        .SYNC_WORD (SYNC_WORD)
    ) u_shift (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_bit  (in_bit),
        .hit     (hit),
        .hit_pol (hit_pol)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_SEARCH;
            good_q  <= '0;
            miss_q  <= '0;
            phase_q <= '0;
            pol_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            miss_q  <= miss_d;
            phase_q <= phase_d;
            pol_q   <= pol_d;
        end
    end

    // phase_q counts bits since the last boundary; bit 32 after it is the next boundary.
    always_comb begin
        state_d     = state_q;
        good_d      = good_q;
        miss_d      = miss_q;
        phase_d     = phase_q;
        pol_d       = pol_q;
        at_boundary = (phase_q == {PHASE_W{1'b1}});
        same_hit    = hit && (hit_pol == pol_q);

        if (in_val) begin
            phase_d = phase_q + PHASE_W'(1);
            case (state_q)
                ST_SEARCH: begin
                    if (hit) begin
                        phase_d = '0;
                        pol_d   = hit_pol;
                        miss_d  = '0;
                        if (LOCK_N == CNT_W'(1)) begin
                            state_d = ST_LOCKED;
                        end else begin
                            state_d = ST_VERIFY;
                            good_d  = CNT_W'(1);
                        end
                    end
                end
                ST_VERIFY: begin
                    if (at_boundary) begin
                        if (same_hit) begin
                            good_d = good_q + CNT_W'(1);
                            if (good_q + CNT_W'(1) == LOCK_N) begin
                                state_d = ST_LOCKED;
                                miss_d  = '0;
                            end
                        end else begin
                            state_d = ST_SEARCH;
                            good_d  = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (at_boundary) begin
                        if (same_hit) begin
                            miss_d = '0;
                        end else if (miss_q + CNT_W'(1) == LOSS_N) begin
                            state_d = ST_SEARCH;
                            miss_d  = '0;
                            good_d  = '0;
                        end else begin
                            miss_d = miss_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match       <= 1'b0;
            match_count <= '0;
        end else begin
            match <= hit;
            if (hit) begin
                match_count <= sat_inc(match_count);
            end
        end
    end

    assign state  = state_q;
    assign locked = (state_q == ST_LOCKED);

`ifdef SYNC_WORD_DETECTOR_INV_EN
    assign polarity = pol_q;
`else
    assign polarity = 1'b0;
`endif

endmodule

// File: doc/sync_word_detector.md
SYNC_WORD_DETECTOR -- requirements
Module: sync_word_detector

Interface
REQ-001 The block SHALL have exactly one clock, `clk`; reset is asynchronous and active-low on port `reset` (asserted when 0).
REQ-002 Parameter SYNC_WORD, default 32'hDEADBEEF, SHALL be the 32-bit word to detect, MSB first.
REQ-003 Parameter LOCK_COUNT, default 3, range 1..15, SHALL be the number of consecutive on-boundary matches needed to lock.
REQ-004 Parameter LOSS_COUNT, default 2, range 1..15, SHALL be the number of consecutive on-boundary misses that drop lock.
REQ-005 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  asynchronous active-low reset.
REQ-007 in_val  input  1  qualifies in_bit; a bit SHALL be accepted only in a cycle with in_val=1 (no back-pressure).
REQ-008 in_bit  input  1  serial data bit.
REQ-009 match  output  1  one-cycle pulse per detected word.
REQ-010 locked  output  1  high while the FSM is in LOCKED.
REQ-011 state  output  2  FSM state: SEARCH=0, VERIFY=1, LOCKED=2.
REQ-012 match_count  output  16  saturating count of match pulses.
REQ-013 polarity  output  1  polarity of the latched lock word (0=true, 1=inverted).

Function
REQ-014 On each accepted bit, the shift register SHALL update as sr <= {sr[30:0], in_bit}.
REQ-015 A fill counter SHALL count accepted bits and saturate at 32; a hit SHALL be declared only when the fill counter is 32 after the shift.
REQ-016 A hit SHALL be declared when the post-shift sr equals SYNC_WORD; match SHALL go high in the cycle after the completing bit is accepted, for exactly one cycle.
REQ-017 Overlapping hits SHALL each pulse match independently.
REQ-018 A phase counter SHALL count accepted bits modulo 32 and be zeroed on every hit used as a boundary; a "boundary" is the 32nd accepted bit after the last boundary.
REQ-019 In SEARCH, any hit SHALL go to LOCKED if LOCK_COUNT=1, else to VERIFY with good_cnt=1; phase SHALL restart in either case.
REQ-020 In VERIFY, a hit at a boundary SHALL increment good_cnt and go to LOCKED when good_cnt reaches LOCK_COUNT; a miss at a boundary SHALL return to SEARCH with the fill counter retained.
REQ-021 In VERIFY and LOCKED, off-boundary hits SHALL pulse match but SHALL NOT alter the FSM or the phase.
REQ-022 In LOCKED, a boundary hit SHALL clear miss_cnt; a boundary miss SHALL increment miss_cnt, and reaching LOSS_COUNT SHALL go to SEARCH.
REQ-023 match_count SHALL increment on every match pulse and hold at 16'hFFFF.
REQ-024 A cycle with in_val=0 SHALL change no state.

Reset
REQ-025 Reset assertion SHALL immediately force match=0, locked=0, state=SEARCH, match_count=0, polarity=0, sr=0, and clear all counters.
REQ-026 Reset asserted mid-word SHALL discard partial fill; detection SHALL require 32 fresh bits after release.

Configuration
REQ-027 With SYNC_WORD_DETECTOR_INV_EN defined, sr == ~SYNC_WORD SHALL also be a hit; polarity SHALL be latched on the SEARCH exit hit, and in VERIFY and LOCKED only same-polarity hits SHALL count as boundary hits.
REQ-028 Without SYNC_WORD_DETECTOR_INV_EN, inverted words SHALL NOT hit and polarity SHALL be tied to 0.

Structure
REQ-029 Package sync_word_pkg SHALL hold the state enum typedef, the default SYNC_WORD constant and the width constants (32, 16).
REQ-030 Sub-module sync_word_shift SHALL contain the shift register, the fill counter and the comparator(s), and output the hit and hit-polarity signals; the FSM and counters SHALL stay in the top module.

Verification
REQ-031 Drive 32 bits of 0xDEADBEEF with in_val=1 after reset -> match pulses 1 cycle after the last bit; state=VERIFY; match_count=1.
REQ-032 Drive three back-to-back copies of 0xDEADBEEF -> locked=1 the cycle after the 96th bit; state=2.
REQ-033 While locked, drive two 32-bit garbage words (0x00000000) -> state=SEARCH and locked=0 after the 64th bit.
REQ-034 Drive the same word with in_val toggled 0/1 every cycle -> identical results to REQ-031, with timing stretched 2x.
REQ-035 Assert reset after 20 bits of the word, then drive the full word -> exactly one match, 32 bits after release.
REQ-036 With SYNC_WORD_DETECTOR_INV_EN defined, drive 0x21524110 three times -> locked=1, polarity=1; with the macro undefined, the same stimulus -> no match.
